// File: rtl/bus_pkg.sv
// bus_pkg: shared constants for the internal-bus drive arbitration.
`default_nettype none

package bus_pkg;

  localparam int N_SRC = 25;
  localparam int IDX_W = $clog2(N_SRC);

  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHIGH  = 18;
  localparam int SRC_ZLOW   = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_RAM    = 23;
  localparam int SRC_C      = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/bus_source_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector; lowest set request at or above
// the pointer wins, otherwise the lowest set request overall.
`default_nettype none

module rr_pick #(
  parameter int N = 25,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_win,
  output logic         o_any
);

  logic [N-1:0] w_mask;
  logic [W-1:0] w_mask_idx;
  logic [W-1:0] w_req_idx;

  always_comb begin
    w_mask     = i_req & ~((N'(1) << i_ptr) - N'(1));
    w_mask_idx = '0;
    w_req_idx  = '0;
    // Descending scan leaves the lowest set index in each encoder.
    for (int i = N - 1; i >= 0; i--) begin
      if (w_mask[i]) w_mask_idx = W'(i);
      if (i_req[i])  w_req_idx  = W'(i);
    end
    o_win = (|w_mask) ? w_mask_idx : w_req_idx;
    o_any = |i_req;
  end

endmodule

`default_nettype wire

// File: rtl/bus_source_arbiter.sv
// bus_source_arbiter: registered round-robin owner of the internal-bus drive
// enables, with a dead cycle between owners and a hold-limit preemption.
`default_nettype none

module bus_source_arbiter #(
  parameter int N_SRC    = bus_pkg::N_SRC,
  parameter int MAX_HOLD = 8,
  parameter int IDX_W    = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [N_SRC-1:0] req,
  input  logic             lock,
  output logic [N_SRC-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             preempt
);

  import bus_pkg::*;

  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [N_SRC-1:0] r_gnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_valid;
  logic             r_preempt;

  logic [IDX_W-1:0] w_win;
  logic             w_any;
  logic [IDX_W-1:0] w_next_ptr;
  logic             w_own_req;
  logic             w_others;
  logic             w_expired;

  rr_pick #(.N(N_SRC), .W(IDX_W)) u_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_win (w_win),
    .o_any (w_any)
  );

  assign w_next_ptr = (w_win == IDX_W'(N_SRC - 1)) ? '0 : w_win + 1'b1;
  assign w_own_req  = |(req & r_gnt);
  assign w_others   = |(req & ~r_gnt);
  assign w_expired  = (r_cnt == CNT_W'(MAX_HOLD));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_idx     <= '0;
      r_valid   <= 1'b0;
      r_preempt <= 1'b0;
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        ST_IDLE, ST_TURN: begin
          if (w_any) begin
            r_gnt   <= N_SRC'(1) << w_win;
            r_idx   <= w_win;
            r_valid <= 1'b1;
            r_cnt   <= '0;
            r_ptr   <= w_next_ptr;
            r_state <= ST_OWN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_OWN: begin
          if (!w_expired) r_cnt <= r_cnt + 1'b1;
          // Release wins over expiry, so preempt only fires while the owner still requests.
          if (!w_own_req || (w_expired && !lock && w_others)) begin
            r_gnt     <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_preempt <= w_own_req;
            r_state   <= ST_TURN;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_idx;
  assign gnt_valid = r_valid;
  assign preempt   = r_preempt;

endmodule

`default_nettype wire
